// File: rtl/inference_sequencer.sv
// Ping-pong scheduler between the image loader and the CNN core over a two-bank image RAM.
// Tracks which bank is filling and which is being read, starts/aborts CNN runs, latches results.
`timescale 1ns/1ps
module inference_sequencer #(
    parameter int IMG_SIZE       = 784,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int TMO_W          = 21
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        weights_loaded,
    input  logic        ld_wr_en,
    input  logic [9:0]  ld_wr_addr,
    input  logic [7:0]  ld_wr_data,
    input  logic        image_loaded,
    output logic        ram_wr_en,
    output logic [10:0] ram_wr_addr,
    output logic [7:0]  ram_wr_data,
    input  logic [9:0]  cnn_rd_addr,
    output logic [10:0] ram_rd_addr,
    output logic        cnn_start,
    output logic        cnn_abort,
    input  logic        cnn_done,
    input  logic [3:0]  cnn_digit,
    output logic [3:0]  result_digit,
    output logic        result_valid,
    output logic        busy,
    output logic        overrun,
    output logic        timeout_err,
    output logic [7:0]  drop_count
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_START, S_RUN} state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_n;
    logic             wr_bank, wr_bank_n;
    logic             rd_bank, rd_bank_n;
    logic [1:0]       bank_full, bank_full_n;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_n;
    logic             done_hit, tmo_hit, drop;

    assign ram_rd_addr = {rd_bank, cnn_rd_addr};

    always_comb begin
        state_n     = state;
        wr_bank_n   = wr_bank;
        rd_bank_n   = rd_bank;
        bank_full_n = bank_full;
        tmo_cnt_n   = tmo_cnt;
        done_hit    = 1'b0;
        tmo_hit     = 1'b0;
        drop        = 1'b0;
        cnn_start   = 1'b0;
        cnn_abort   = 1'b0;
        busy        = 1'b0;

        case (state)
            S_IDLE:  if (weights_loaded) state_n = S_WAIT;
            S_WAIT:  if (bank_full[rd_bank]) state_n = S_START;
            S_START: begin
                cnn_start = 1'b1;
                busy      = 1'b1;
                tmo_cnt_n = '0;
                state_n   = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnn_done) begin
                    done_hit = 1'b1;
                    state_n  = S_WAIT;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit   = 1'b1;
                    cnn_abort = 1'b1;
                    state_n   = S_WAIT;
                end else begin
                    tmo_cnt_n = tmo_cnt + TMO_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Free first so a bank released this cycle can take an image arriving this cycle.
        if (done_hit || tmo_hit) begin
            bank_full_n[rd_bank] = 1'b0;
            rd_bank_n            = ~rd_bank;
        end
        if (bank_full_n[wr_bank_n] && !bank_full_n[~wr_bank_n])
            wr_bank_n = ~wr_bank_n;

        if (image_loaded && state != S_IDLE) begin
            if (!bank_full_n[wr_bank_n]) begin
                bank_full_n[wr_bank_n] = 1'b1;
                if (!bank_full_n[~wr_bank_n])
                    wr_bank_n = ~wr_bank_n;
            end else begin
                drop = 1'b1;
            end
        end

        if (!weights_loaded) begin
            state_n     = S_IDLE;
            bank_full_n = '0;
            wr_bank_n   = 1'b0;
            rd_bank_n   = 1'b0;
            done_hit    = 1'b0;
            tmo_hit     = 1'b0;
            drop        = 1'b0;
            cnn_abort   = (state == S_START) || (state == S_RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            bank_full    <= '0;
            tmo_cnt      <= '0;
            ram_wr_en    <= 1'b0;
            ram_wr_addr  <= '0;
            ram_wr_data  <= '0;
            result_digit <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
            timeout_err  <= 1'b0;
            drop_count   <= '0;
        end else begin
            state        <= state_n;
            wr_bank      <= wr_bank_n;
            rd_bank      <= rd_bank_n;
            bank_full    <= bank_full_n;
            tmo_cnt      <= tmo_cnt_n;
            ram_wr_en    <= ld_wr_en && !bank_full[wr_bank] && (state != S_IDLE);
            ram_wr_addr  <= {wr_bank, ld_wr_addr};
            ram_wr_data  <= ld_wr_data;
            result_valid <= done_hit;
            if (done_hit) result_digit <= cnn_digit;
            if (tmo_hit) timeout_err <= 1'b1;
            if (drop) begin
                overrun <= 1'b1;
                if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end
        end
    end

    ld_addr_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        ld_wr_en |-> (int'(ld_wr_addr) < IMG_SIZE));

endmodule

// File: tb/tb_inference_sequencer.sv
// Bench for inference_sequencer: directed vector table, hand-built load/timeout/reset sequences,
// and randomized traffic checked against a queue-based model of the bank scheduling rules.
`timescale 1ns/1ps
module tb_inference_sequencer;

    localparam int T = 100;

    logic        clk = 1'b0;
    logic        rst_n, weights_loaded, ld_wr_en, image_loaded, cnn_done;
    logic [9:0]  ld_wr_addr, cnn_rd_addr;
    logic [7:0]  ld_wr_data;
    logic [3:0]  cnn_digit;
    logic        ram_wr_en, cnn_start, cnn_abort, result_valid, busy, overrun, timeout_err;
    logic [10:0] ram_wr_addr, ram_rd_addr;
    logic [7:0]  ram_wr_data, drop_count;
    logic [3:0]  result_digit;

    always #5 clk = ~clk;

    inference_sequencer #(.IMG_SIZE(784), .TIMEOUT_CYCLES(T), .TMO_W(21)) dut (
        .clk(clk), .rst_n(rst_n), .weights_loaded(weights_loaded),
        .ld_wr_en(ld_wr_en), .ld_wr_addr(ld_wr_addr), .ld_wr_data(ld_wr_data),
        .image_loaded(image_loaded), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data), .cnn_rd_addr(cnn_rd_addr), .ram_rd_addr(ram_rd_addr),
        .cnn_start(cnn_start), .cnn_abort(cnn_abort), .cnn_done(cnn_done),
        .cnn_digit(cnn_digit), .result_digit(result_digit), .result_valid(result_valid),
        .busy(busy), .overrun(overrun), .timeout_err(timeout_err), .drop_count(drop_count)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int w, wen, waddr, il, done, digit, rdaddr;
        int e_wen, e_waddr, e_start, e_abort, e_busy, e_rv, e_rdig, e_ovr, e_drops, e_rdaddr;
    } vec_t;

    vec_t tbl[19];

    // Reference model: full banks held as a FIFO of bank ids; run_age -1 = no run,
    // 0 = start cycle, n>0 = n-th cycle after the start pulse.
    int m_act, m_wr, m_rd, m_age;
    int m_q[$];
    logic        e_wen, e_rv, e_ovr, e_terr;
    logic [10:0] e_waddr;
    logic [7:0]  e_wdata, e_drops;
    logic [3:0]  e_rdig;

    function automatic bit has(input int b);
        foreach (m_q[i]) if (m_q[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_act = 0; m_wr = 0; m_rd = 0; m_age = -1; m_q.delete();
        e_wen = 0; e_waddr = '0; e_wdata = '0; e_rv = 0; e_rdig = '0;
        e_ovr = 0; e_terr = 0; e_drops = '0;
    endtask

    task automatic model_step();
        bit was_ready, freed;
        was_ready = (m_q.size() > 0);
        freed     = 0;
        e_wen   = ld_wr_en && (m_act != 0) && !has(m_wr);
        e_waddr = 11'(m_wr * 1024 + int'(ld_wr_addr));
        e_wdata = ld_wr_data;
        e_rv    = 0;
        if (!weights_loaded) begin
            m_act = 0; m_q.delete(); m_wr = 0; m_rd = 0; m_age = -1;
        end else if (m_act == 0) begin
            m_act = 1;
        end else begin
            if (m_age >= 1 && cnn_done) begin
                e_rdig = cnn_digit; e_rv = 1; freed = 1;
            end else if (m_age == T) begin
                e_terr = 1; freed = 1;
            end
            if (freed) begin
                void'(m_q.pop_front()); m_rd = 1 - m_rd; m_age = -1;
            end else if (m_age >= 0) begin
                m_age++;
            end else if (was_ready) begin
                m_age = 0;
            end
            if (has(m_wr) && !has(1 - m_wr)) m_wr = 1 - m_wr;
            if (image_loaded) begin
                if (!has(m_wr)) begin
                    m_q.push_back(m_wr);
                    if (!has(1 - m_wr)) m_wr = 1 - m_wr;
                end else begin
                    e_ovr = 1;
                    if (e_drops != 8'hFF) e_drops = e_drops + 8'd1;
                end
            end
        end
    endtask

    initial begin
        int n, m, bad;
        bit wr_ok, saw_rv;

        //           w wen waddr il dn dg rda | wen waddr st ab bz rv rdg ov drp rdaddr
        tbl[0]  = '{0, 1, 5, 0, 0, 0, 3,   0, 0,    0, 0, 0, 0, 0, 0, 0, 3};
        tbl[1]  = '{1, 1, 6, 0, 0, 0, 3,   0, 5,    0, 0, 0, 0, 0, 0, 0, 3};
        tbl[2]  = '{1, 1, 7, 0, 0, 0, 3,   0, 6,    0, 0, 0, 0, 0, 0, 0, 3};
        tbl[3]  = '{1, 0, 0, 1, 0, 0, 3,   1, 7,    0, 0, 0, 0, 0, 0, 0, 3};
        tbl[4]  = '{1, 1, 9, 0, 0, 0, 3,   0, 0,    0, 0, 0, 0, 0, 0, 0, 3};
        tbl[5]  = '{1, 0, 0, 0, 1, 0, 3,   1, 1033, 1, 0, 1, 0, 0, 0, 0, 3};
        tbl[6]  = '{1, 0, 0, 0, 0, 0, 3,   0, 1024, 0, 0, 1, 0, 0, 0, 0, 3};
        tbl[7]  = '{1, 0, 0, 0, 1, 7, 3,   0, 1024, 0, 0, 1, 0, 0, 0, 0, 3};
        tbl[8]  = '{1, 0, 0, 0, 0, 0, 3,   0, 1024, 0, 0, 0, 1, 7, 0, 0, 1027};
        tbl[9]  = '{1, 0, 0, 1, 0, 0, 3,   0, 1024, 0, 0, 0, 0, 7, 0, 0, 1027};
        tbl[10] = '{1, 0, 0, 1, 0, 0, 3,   0, 1024, 0, 0, 0, 0, 7, 0, 0, 1027};
        tbl[11] = '{1, 1, 2, 1, 0, 0, 3,   0, 0,    1, 0, 1, 0, 7, 0, 0, 1027};
        tbl[12] = '{1, 1, 2, 0, 0, 0, 3,   0, 2,    0, 0, 1, 0, 7, 1, 1, 1027};
        tbl[13] = '{1, 1, 4, 1, 1, 3, 0,   0, 2,    0, 0, 1, 0, 7, 1, 1, 1024};
        tbl[14] = '{1, 1, 4, 0, 0, 0, 0,   0, 4,    0, 0, 0, 1, 3, 1, 1, 0};
        tbl[15] = '{1, 0, 0, 0, 0, 0, 0,   0, 1028, 1, 0, 1, 0, 3, 1, 1, 0};
        tbl[16] = '{0, 0, 0, 0, 0, 0, 0,   0, 1024, 0, 1, 1, 0, 3, 1, 1, 0};
        tbl[17] = '{0, 1, 1, 0, 0, 0, 0,   0, 1024, 0, 0, 0, 0, 3, 1, 1, 0};
        tbl[18] = '{0, 0, 0, 0, 0, 0, 0,   0, 1,    0, 0, 0, 0, 3, 1, 1, 0};

        rst_n = 0; weights_loaded = 0; ld_wr_en = 0; ld_wr_addr = '0; ld_wr_data = '0;
        image_loaded = 0; cnn_done = 0; cnn_digit = '0; cnn_rd_addr = '0;
        step(); step();
        rst_n = 1;

        for (int i = 0; i < 19; i++) begin
            weights_loaded = tbl[i].w[0];
            ld_wr_en       = tbl[i].wen[0];
            ld_wr_addr     = 10'(tbl[i].waddr);
            ld_wr_data     = '0;
            image_loaded   = tbl[i].il[0];
            cnn_done       = tbl[i].done[0];
            cnn_digit      = 4'(tbl[i].digit);
            cnn_rd_addr    = 10'(tbl[i].rdaddr);
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  64'({ram_wr_en, ram_wr_addr, cnn_start, cnn_abort, busy, result_valid,
                       result_digit, overrun, drop_count, ram_rd_addr}),
                  64'({1'(tbl[i].e_wen), 11'(tbl[i].e_waddr), 1'(tbl[i].e_start),
                       1'(tbl[i].e_abort), 1'(tbl[i].e_busy), 1'(tbl[i].e_rv),
                       4'(tbl[i].e_rdig), 1'(tbl[i].e_ovr), 8'(tbl[i].e_drops),
                       11'(tbl[i].e_rdaddr)}));
            @(posedge clk); #1;
        end

        // Reset in the middle of a load clears every register, sticky flags included.
        weights_loaded = 1; ld_wr_en = 0; image_loaded = 0; cnn_done = 0; cnn_rd_addr = '0;
        step(); step();
        ld_wr_en = 1; ld_wr_addr = 10'd10; ld_wr_data = 8'h3C;
        step();
        check("preload_write", 64'({ram_wr_en, ram_wr_addr, ram_wr_data}), 64'({1'b1, 11'd10, 8'h3C}));
        rst_n = 0;
        step();
        check("reset_outputs",
              64'({ram_wr_en, ram_wr_addr, ram_wr_data, cnn_start, cnn_abort, busy, result_valid,
                   result_digit, overrun, timeout_err, drop_count, ram_rd_addr}), 64'(0));
        rst_n = 1; ld_wr_en = 0;
        step();

        // Full image into bank 0.
        bad = 0;
        for (int i = 0; i < 784; i++) begin
            ld_wr_en = 1; ld_wr_addr = 10'(i); ld_wr_data = 8'(i * 3);
            step();
            if (!(ram_wr_en === 1'b1 && ram_wr_addr === 11'(i) && ram_wr_data === 8'(i * 3))) bad++;
        end
        check("load_a_pixels_bad", 64'(bad), 64'(0));
        ld_wr_en = 0; image_loaded = 1; cnn_rd_addr = 10'h155;
        step();
        image_loaded = 0;
        check("start_not_early", 64'(cnn_start), 64'(0));
        step();
        check("start_after_2", 64'({cnn_start, busy}), 64'(2'b11));
        check("rd_bank0_addr", 64'(ram_rd_addr), 64'(11'h155));

        // CNN never answers; a second image is queued into bank 1 meanwhile.
        n = 0; wr_ok = 0; saw_rv = 0;
        while (cnn_abort !== 1'b1 && n < 200) begin
            if (n == 5) begin
                ld_wr_en = 1; ld_wr_addr = '0; ld_wr_data = 8'hEE;
            end else if (n == 6) begin
                wr_ok = (ram_wr_en === 1'b1 && ram_wr_addr === 11'd1024);
                ld_wr_en = 0; image_loaded = 1;
            end else if (n == 7) begin
                image_loaded = 0;
            end
            step();
            n++;
            if (result_valid === 1'b1) saw_rv = 1;
        end
        check("timeout_latency", 64'(n), 64'(T));
        check("bank1_write", 64'(wr_ok), 64'(1));
        check("no_result_on_timeout", 64'(saw_rv), 64'(0));
        step();
        check("timeout_err_abort_pulse", 64'({timeout_err, cnn_abort, result_valid}), 64'(3'b100));
        m = 0;
        while (cnn_start !== 1'b1 && m < 10) begin
            step();
            m++;
        end
        check("next_bank_start", 64'({cnn_start, ram_rd_addr}), 64'({1'b1, 11'h555}));

        // Randomized traffic against the model.
        rst_n = 0; weights_loaded = 1; ld_wr_en = 0; image_loaded = 0; cnn_done = 0;
        step();
        rst_n = 1;
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            if (weights_loaded) weights_loaded = ($urandom_range(0, 299) != 0);
            else                weights_loaded = ($urandom_range(0, 9) == 0);
            ld_wr_en     = 1'($urandom_range(0, 1));
            ld_wr_addr   = 10'($urandom_range(0, 783));
            ld_wr_data   = 8'($urandom);
            image_loaded = ($urandom_range(0, 24) == 0);
            cnn_done     = ($urandom_range(0, 39) == 0);
            cnn_digit    = 4'($urandom);
            cnn_rd_addr  = 10'($urandom);
            @(negedge clk);
            check("rnd_write", 64'({ram_wr_en, ram_wr_addr, ram_wr_data}), 64'({e_wen, e_waddr, e_wdata}));
            check("rnd_ctl", 64'({cnn_start, cnn_abort, busy}),
                  64'({m_age == 0,
                       weights_loaded ? (m_age == T && !cnn_done) : (m_age >= 0),
                       m_age >= 0}));
            check("rnd_result", 64'({result_valid, result_digit}), 64'({e_rv, e_rdig}));
            check("rnd_flags", 64'({overrun, timeout_err, drop_count}), 64'({e_ovr, e_terr, e_drops}));
            check("rnd_rd_addr", 64'(ram_rd_addr), 64'(m_rd * 1024 + int'(cnn_rd_addr)));
            model_step();
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
